// File: rtl/dmem_responder.sv
// Data-side memory responder: runs one load/store/LL/SC per pipeline request as a
// single word transaction on the dREN/dWEN/dwait bus and maintains the LL/SC link.
module dmem_responder #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int WOFF   = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              dmemREN,
   input  logic              dmemWEN,
   input  logic              datomic,
   input  logic [ADDR_W-1:0] dmemaddr,
   input  logic [DATA_W-1:0] dmemstore,
   output logic              dhit,
   output logic [DATA_W-1:0] dmemload,
   output logic              dREN,
   output logic              dWEN,
   output logic [ADDR_W-1:0] daddr,
   output logic [DATA_W-1:0] dstore,
   input  logic [DATA_W-1:0] dload,
   input  logic              dwait,
   input  logic              snoop_valid,
   input  logic [ADDR_W-1:0] snoop_addr
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t                 state, state_nxt;
   logic                   op_wr, op_atomic;
   logic [ADDR_W-1:0]      addr_q;
   logic [DATA_W-1:0]      store_q;
   logic                   link_valid;
   logic [ADDR_W-WOFF-1:0] link_addr;
   logic [ADDR_W-1:0]      link_byte;
   logic                   snoop_hit, link_match, accept, sc_fail, bus_done;

   // Word-granular compare; xor-then-shift keeps the byte-offset bits out of the match.
   function automatic logic word_eq(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
      return ((a ^ b) >> WOFF) == '0;
   endfunction

   assign link_byte  = {link_addr, {WOFF{1'b0}}};
   assign snoop_hit  = snoop_valid && link_valid && word_eq(snoop_addr, link_byte);
   // A snoop landing in the same cycle as the SC check is ordered first, so it kills the SC.
   assign link_match = link_valid && word_eq(dmemaddr, link_byte) && !snoop_hit;
   assign bus_done   = (state == BUS) && !dwait;

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      sc_fail   = 1'b0;
      case (state)
         IDLE: begin
            if (dmemREN || dmemWEN) begin
               accept = 1'b1;
               if (!dmemREN && datomic && !link_match) begin
                  sc_fail   = 1'b1;
                  state_nxt = RESP;
               end else begin
                  state_nxt = BUS;
               end
            end
         end
         BUS:     if (!dwait) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         op_wr      <= 1'b0;
         op_atomic  <= 1'b0;
         addr_q     <= '0;
         store_q    <= '0;
         dmemload   <= '0;
         link_valid <= 1'b0;
         link_addr  <= '0;
      end else begin
         if (accept) begin
            op_wr     <= !dmemREN;
            op_atomic <= datomic;
            addr_q    <= dmemaddr;
            store_q   <= dmemstore;
         end
         if (sc_fail) dmemload <= '0;
         if (bus_done) begin
            if (!op_wr)        dmemload <= dload;
            else if (op_atomic) dmemload <= DATA_W'(1);
         end
         if (snoop_hit || sc_fail) link_valid <= 1'b0;
         if (bus_done && op_wr && (op_atomic || word_eq(addr_q, link_byte)))
            link_valid <= 1'b0;
         // LL completion wins over a same-cycle snoop: the snoop is ordered before it.
         if (bus_done && !op_wr && op_atomic) begin
            link_valid <= 1'b1;
            link_addr  <= addr_q[ADDR_W-1:WOFF];
         end
      end
   end

   assign dhit   = (state == RESP);
   assign dREN   = (state == BUS) && !op_wr;
   assign dWEN   = (state == BUS) && op_wr;
   assign daddr  = addr_q;
   assign dstore = store_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: hand-computed vectors for loads, stores,
// LL/SC link behaviour, snoop ordering and mid-transaction reset.
module tb_dmem_responder;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        dmemREN = 1'b0, dmemWEN = 1'b0, datomic = 1'b0;
   logic [31:0] dmemaddr = '0, dmemstore = '0;
   logic        dhit;
   logic [31:0] dmemload;
   logic        dREN, dWEN;
   logic [31:0] daddr, dstore;
   logic [31:0] dload = '0;
   logic        dwait = 1'b0;
   logic        snoop_valid = 1'b0;
   logic [31:0] snoop_addr = '0;

   int nvec = 0;
   int nerr = 0;

   dmem_responder dut (
      .CLK(CLK), .RST(RST),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .dhit(dhit), .dmemload(dmemload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request with zero wait states; bus=0 means a failed SC (dhit at T+1).
   task automatic xact(input string tag, input logic ren, input logic wen, input logic at,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic bus, input logic [31:0] exp_load);
      dmemREN = ren; dmemWEN = wen; datomic = at; dmemaddr = addr; dmemstore = data;
      tick();
      if (bus) begin
         check({tag, ".strobe"}, {30'd0, dREN, dWEN}, {30'd0, ren, wen && !ren});
         check({tag, ".daddr"}, daddr, addr);
         if (!ren) check({tag, ".dstore"}, dstore, data);
         check({tag, ".early"}, {31'd0, dhit}, 32'd0);
         tick();
      end
      check({tag, ".dhit"}, {31'd0, dhit}, 32'd1);
      check({tag, ".load"}, dmemload, exp_load);
      check({tag, ".idle_strobe"}, {30'd0, dREN, dWEN}, 32'd0);
      dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
      tick();
      check({tag, ".one_pulse"}, {31'd0, dhit}, 32'd0);
   endtask

   initial begin
      tick(); tick();
      check("rst.dhit", {31'd0, dhit}, 32'd0);
      check("rst.strobe", {30'd0, dREN, dWEN}, 32'd0);
      check("rst.daddr", daddr, 32'd0);
      check("rst.dstore", dstore, 32'd0);
      check("rst.dmemload", dmemload, 32'd0);
      RST = 1'b0;
      tick();

      // Load with three wait states: dREN held four cycles.
      dmemREN = 1'b1; dmemaddr = 32'h40; dload = 32'hDEADBEEF; dwait = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("ws.dREN", {31'd0, dREN}, 32'd1);
         check("ws.daddr", daddr, 32'h40);
         check("ws.nohit", {31'd0, dhit}, 32'd0);
         if (i == 3) dwait = 1'b0;
         tick();
      end
      check("ws.dhit", {31'd0, dhit}, 32'd1);
      check("ws.load", dmemload, 32'hDEADBEEF);
      check("ws.dREN_off", {31'd0, dREN}, 32'd0);
      dmemREN = 1'b0;
      tick();
      check("ws.one_pulse", {31'd0, dhit}, 32'd0);
      check("ws.hold", dmemload, 32'hDEADBEEF);

      // Store, zero wait.
      xact("st80", 1'b0, 1'b1, 1'b0, 32'h80, 32'h1234, 1'b1, 32'hDEADBEEF);

      // LL then SC success; link then cleared so a repeat SC fails.
      dload = 32'h55;
      xact("ll1", 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'h55);
      xact("sc1", 1'b0, 1'b1, 1'b1, 32'h100, 32'h7, 1'b1, 32'h1);
      xact("sc1b", 1'b0, 1'b1, 1'b1, 32'h100, 32'h9, 1'b0, 32'h0);

      // Snoop to the same word kills the link.
      xact("ll2", 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'h55);
      snoop_valid = 1'b1; snoop_addr = 32'h102;
      tick();
      snoop_valid = 1'b0;
      xact("sc2", 1'b0, 1'b1, 1'b1, 32'h100, 32'h7, 1'b0, 32'h0);

      // SC to a different word fails and clears the link.
      xact("ll3", 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'h55);
      xact("sc3a", 1'b0, 1'b1, 1'b1, 32'h104, 32'h7, 1'b0, 32'h0);
      xact("sc3b", 1'b0, 1'b1, 1'b1, 32'h100, 32'h7, 1'b0, 32'h0);

      // Snoop to another word leaves the link intact.
      xact("ll4", 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'h55);
      snoop_valid = 1'b1; snoop_addr = 32'h108;
      tick();
      snoop_valid = 1'b0;
      xact("sc4", 1'b0, 1'b1, 1'b1, 32'h100, 32'h3, 1'b1, 32'h1);

      // Snoop in the same cycle IDLE evaluates the SC: SC fails.
      xact("ll5", 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'h55);
      snoop_valid = 1'b1; snoop_addr = 32'h100;
      dmemWEN = 1'b1; datomic = 1'b1; dmemaddr = 32'h100; dmemstore = 32'h7;
      tick();
      snoop_valid = 1'b0;
      check("sc5.dhit", {31'd0, dhit}, 32'd1);
      check("sc5.nowen", {31'd0, dWEN}, 32'd0);
      check("sc5.load", dmemload, 32'h0);
      dmemWEN = 1'b0; datomic = 1'b0;
      tick();

      // Snoop while the SC is already on the bus does not abort it.
      xact("ll6", 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'h55);
      dmemWEN = 1'b1; datomic = 1'b1; dmemaddr = 32'h100; dmemstore = 32'h8;
      tick();
      check("sc6.dWEN", {31'd0, dWEN}, 32'd1);
      snoop_valid = 1'b1; snoop_addr = 32'h100;
      tick();
      snoop_valid = 1'b0;
      check("sc6.dhit", {31'd0, dhit}, 32'd1);
      check("sc6.load", dmemload, 32'h1);
      dmemWEN = 1'b0; datomic = 1'b0;
      tick();

      // Snoop in the cycle the LL completes: the link is still set.
      dload = 32'h66;
      dmemREN = 1'b1; datomic = 1'b1; dmemaddr = 32'h100;
      tick();
      snoop_valid = 1'b1; snoop_addr = 32'h100;
      tick();
      snoop_valid = 1'b0;
      check("ll7.dhit", {31'd0, dhit}, 32'd1);
      check("ll7.load", dmemload, 32'h66);
      dmemREN = 1'b0; datomic = 1'b0;
      tick();
      xact("sc7", 1'b0, 1'b1, 1'b1, 32'h100, 32'h4, 1'b1, 32'h1);

      // Own store to the linked word clears the link; to another word it does not.
      xact("ll8", 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'h66);
      xact("st8", 1'b0, 1'b1, 1'b0, 32'h100, 32'hAA, 1'b1, 32'h66);
      xact("sc8", 1'b0, 1'b1, 1'b1, 32'h100, 32'h5, 1'b0, 32'h0);
      xact("ll9", 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'h66);
      xact("st9", 1'b0, 1'b1, 1'b0, 32'h200, 32'hBB, 1'b1, 32'h66);
      xact("sc9", 1'b0, 1'b1, 1'b1, 32'h100, 32'h5, 1'b1, 32'h1);

      // Both strobes requested: load wins.
      dload = 32'h77;
      xact("both", 1'b1, 1'b1, 1'b0, 32'h300, 32'h1, 1'b1, 32'h77);

      // Reset mid-transaction abandons it.
      dmemREN = 1'b1; dmemaddr = 32'h40; dwait = 1'b1;
      tick();
      check("rstm.dREN", {31'd0, dREN}, 32'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0; dmemREN = 1'b0; dwait = 1'b0;
      check("rstm.dREN_off", {31'd0, dREN}, 32'd0);
      check("rstm.nohit", {31'd0, dhit}, 32'd0);
      tick();
      check("rstm.nohit2", {31'd0, dhit}, 32'd0);
      dload = 32'hCAFEF00D;
      xact("after_rst", 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 1'b1, 32'hCAFEF00D);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
